// File: rtl/led_matrix_scan_pkg.sv
// Shared display definitions for the 8x8 red/green LED matrix scanner:
// geometry, colour encodings, scan states and pixel/column helpers.
package led_matrix_scan_pkg;

  localparam int unsigned MATRIX_ROWS  = 8;
  localparam int unsigned MATRIX_COLS  = 8;
  localparam int unsigned COLOR_BITS   = 2;
  localparam int unsigned FRAME_BITS   = MATRIX_ROWS * MATRIX_COLS * COLOR_BITS;
  localparam int unsigned ROW_W        = $clog2(MATRIX_ROWS);
  localparam int unsigned FRAME_IDX_W  = $clog2(FRAME_BITS);
  localparam int unsigned PWM_W        = 4;

  typedef enum logic [COLOR_BITS-1:0] {
    COLOR_OFF    = 2'b00,
    COLOR_GREEN  = 2'b01,
    COLOR_RED    = 2'b10,
    COLOR_YELLOW = 2'b11
  } color_e;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [MATRIX_COLS-1:0] red;
    logic [MATRIX_COLS-1:0] green;
  } col_drive_t;

  // Lowest bit index of pixel (row, col) in the frame bus; bit+1 is red, bit+0 is green.
  function automatic int unsigned pixel_bit(input int unsigned row, input int unsigned col);
    return COLOR_BITS * (row * MATRIX_COLS + col);
  endfunction

  // Wide enough for the longer of the two dwell intervals, never zero bits.
  function automatic int unsigned dwell_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Column drive pattern for one row of a frame snapshot.
  function automatic col_drive_t row_drive(input logic [FRAME_BITS-1:0] frame,
                                           input logic [ROW_W-1:0]      row);
    col_drive_t                 d;
    logic [FRAME_IDX_W-1:0]     idx;
    logic [COLOR_BITS-1:0]      px;
    d = '0;
    for (int unsigned c = 0; c < MATRIX_COLS; c++) begin
      idx        = FRAME_IDX_W'(pixel_bit(32'(row), c));
      px         = frame[idx +: COLOR_BITS];
      d.red[c]   = (px == COLOR_RED)   || (px == COLOR_YELLOW);
      d.green[c] = (px == COLOR_GREEN) || (px == COLOR_YELLOW);
    end
    return d;
  endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// Dwell counter for the row scanner: counts cycles in the current state and
// raises a terminal-count strobe on the last cycle of a blank or show interval.
module led_matrix_scan_timer
  import led_matrix_scan_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = dwell_width(ROW_CYCLES, BLANK_CYCLES)
) (
  input  logic             clk,
  input  logic             sw,
  input  logic             show_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last_c;

  // Counter wraps to zero on terminal count, which is exactly when the state changes.
  always_comb begin
    last_c = show_i ? CNT_W'(ROW_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);
    tc_c_o = (cnt_q == last_c);
    cnt_d  = tc_c_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!sw) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for the 8x8 red/green LED matrix: snapshots the frame bus
// at the start of row 0 and scans rows with a blanking gap. Optional BRIGHTNESS_PWM_EN.
module led_matrix_scan
  import led_matrix_scan_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   sw,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [PWM_W-1:0]       brightness,
`endif
  input  logic [FRAME_BITS-1:0]  matrix_data,
  output logic [MATRIX_ROWS-1:0] row_n,
  output logic [MATRIX_COLS-1:0] col_r,
  output logic [MATRIX_COLS-1:0] col_g,
  output logic                   frame_start
);

  localparam int unsigned CNT_W = dwell_width(ROW_CYCLES, BLANK_CYCLES);

  scan_state_e            state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [FRAME_BITS-1:0]  shadow_q;
  logic [MATRIX_ROWS-1:0] row_n_q, row_n_d;
  logic [MATRIX_COLS-1:0] col_r_q, col_r_d;
  logic [MATRIX_COLS-1:0] col_g_q, col_g_d;
  logic                   frame_start_q, frame_start_d;
  logic [CNT_W-1:0]       cnt;
  logic                   tc_c;
  logic                   snap_c;
  logic                   cols_on_c;
  col_drive_t             drive_c;
`ifdef BRIGHTNESS_PWM_EN
  logic [PWM_W-1:0]       bright_q;
`endif

  led_matrix_scan_timer #(
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_scan_timer (
    .clk    (clk),
    .sw     (sw),
    .show_i (state_q == ST_SHOW),
    .cnt_o  (cnt),
    .tc_c_o (tc_c)
  );

  // Next state, snapshot strobe and next output values from the current scan position.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    snap_c        = (state_q == ST_BLANK) && (row_q == '0) && (cnt == '0);
    row_n_d       = '1;
    col_r_d       = '0;
    col_g_d       = '0;
    frame_start_d = snap_c;
    drive_c       = row_drive(shadow_q, row_q);
    cols_on_c     = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
    cols_on_c     = (PWM_W'(cnt) <= bright_q);
`endif

    if (tc_c) begin
      case (state_q)
        ST_BLANK: state_d = ST_SHOW;
        ST_SHOW: begin
          state_d = ST_BLANK;
          row_d   = row_q + ROW_W'(1);
        end
        default: state_d = ST_BLANK;
      endcase
    end

    if (state_q == ST_SHOW) begin
      row_n_d = ~(MATRIX_ROWS'(1) << row_q);
      if (cols_on_c) begin
        col_r_d = drive_c.red;
        col_g_d = drive_c.green;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sw) begin
      state_q       <= ST_BLANK;
      row_q         <= '0;
      shadow_q      <= '0;
      row_n_q       <= '1;
      col_r_q       <= '0;
      col_g_q       <= '0;
      frame_start_q <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
      bright_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      row_n_q       <= row_n_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      frame_start_q <= frame_start_d;
      if (snap_c) begin
        shadow_q <= matrix_data;
`ifdef BRIGHTNESS_PWM_EN
        bright_q <= brightness;
`endif
      end
    end
  end

  assign row_n       = row_n_q;
  assign col_r       = col_r_q;
  assign col_g       = col_g_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomised bench for led_matrix_scan against a timeline model of the scan
// (ROW_CYCLES=4, BLANK_CYCLES=2).
module tb_led_matrix_scan;

  localparam int RC      = 4;
  localparam int BC      = 2;
  localparam int ROW_P   = RC + BC;
  localparam int FRAME_P = 8 * ROW_P;

  logic         clk = 1'b0;
  logic         sw;
  logic [127:0] matrix_data;
  logic [3:0]   brightness;
  logic [7:0]   row_n;
  logic [7:0]   col_r;
  logic [7:0]   col_g;
  logic         frame_start;

  int           errors = 0;
  int           checks = 0;
  int           t      = -1;
  int           cyc    = 0;
  int           last_fs = -1;
  logic [127:0] snap    = '0;
  logic [3:0]   snap_br = '0;

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .sw          (sw),
`ifdef BRIGHTNESS_PWM_EN
    .brightness  (brightness),
`endif
    .matrix_data (matrix_data),
    .row_n       (row_n),
    .col_r       (col_r),
    .col_g       (col_g),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // t = posedges since reset release; every frame of FRAME_P cycles starts with a snapshot,
  // each row is BC blank cycles followed by RC lit cycles.
  task automatic step();
    int           r;
    int           ph;
    int           dw;
    bit           lit;
    logic [7:0]   en;
    logic [7:0]   er;
    logic [7:0]   eg;
    logic         ef;
    logic [127:0] sh;
    @(posedge clk);
    cyc++;
    if (!sw) begin
      t       = -1;
      last_fs = -1;
    end else begin
      t++;
      if (t % FRAME_P == 0) begin
        snap    = matrix_data;
        snap_br = brightness;
      end
    end
    #1;
    en = 8'hFF;
    er = 8'h00;
    eg = 8'h00;
    ef = 1'b0;
    if (t >= 0) begin
      ef = (t % FRAME_P == 0);
      r  = (t % FRAME_P) / ROW_P;
      ph = t % ROW_P;
      if (ph >= BC) begin
        en  = ~(8'(1) << r);
        dw  = ph - BC;
        lit = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
        lit = ((dw % 16) <= int'(snap_br));
`endif
        if (lit) begin
          for (int c = 0; c < 8; c++) begin
            sh    = snap >> (2 * (r * 8 + c));
            er[c] = sh[1];
            eg[c] = sh[0];
          end
        end
      end
    end
    check("row_n", 32'(row_n), 32'(en));
    check("col_r", 32'(col_r), 32'(er));
    check("col_g", 32'(col_g), 32'(eg));
    check("frame_start", 32'(frame_start), 32'(ef));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("frame_gap", 32'(cyc - last_fs), 32'(FRAME_P));
      last_fs = cyc;
    end
  endtask

  initial begin
    int guard;
    sw          = 1'b0;
    matrix_data = rand128();
    brightness  = 4'd15;

    // Held in reset
    repeat (3) step();

    // All-red frame, full wrap through rows 7 -> 0
    matrix_data = {64{2'b10}};
    sw          = 1'b1;
    repeat (60) step();

    // Single green pixel at row 3 col 5, picked up at the next snapshot
    matrix_data     = '0;
    matrix_data[58] = 1'b1;
    repeat (100) step();

    // Data and brightness changing at arbitrary times
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) matrix_data = rand128();
      brightness = 4'($urandom);
      step();
    end

    // Reset asserted while row 4 is lit
    guard = 0;
    while (!(t >= 0 && (t % FRAME_P) / ROW_P == 4 && (t % ROW_P) >= BC + 1) && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("reach_row4", 32'(guard), 32'(0));
    matrix_data = rand128();
    sw          = 1'b0;
    step();
    sw          = 1'b1;
    repeat (60) step();

    // Random resets sprinkled over random frames
    repeat (400) begin
      sw = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 5) == 0) matrix_data = rand128();
      brightness = 4'($urandom);
      step();
    end
    sw = 1'b1;
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
